// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions: divider FSM states and special result constants.
package arith_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CALC = ST_CALC,
    DONE = ST_DONE
  } div_state_t;

  localparam int unsigned MAX_WIDTH = 32;

  // Quotient reported for a zero divisor; sliced to the operand width at use.
  localparam logic [MAX_WIDTH-1:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/cla_subtractor.sv
// N-bit carry-lookahead subtractor: diff = a - b as a + ~b + 1; cout=1 means no borrow.
module cla_subtractor #(
  parameter int unsigned N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         cout
);

  localparam logic CIN = 1'b1;

  logic [N-1:0] bn;
  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   c;
  logic         cf;
  logic         pp;

  // Each carry is a flat sum of generate terms gated by the propagate prefix above them.
  always_comb begin
    bn   = ~b;
    g    = a & bn;
    p    = a ^ bn;
    c    = '0;
    cf   = 1'b0;
    pp   = 1'b1;
    c[0] = CIN;
    for (int i = 0; i < int'(N); i++) begin
      cf = 1'b0;
      pp = 1'b1;
      for (int j = i; j >= 0; j--) begin
        cf = cf | (pp & g[j]);
        pp = pp & p[j];
      end
      c[i+1] = cf | (pp & CIN);
    end
  end

  assign diff = p ^ c[N-1:0];
  assign cout = c[N];

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
module seq_restoring_divider
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  div_state_t       state_q;
  div_state_t       state_d;
  logic [WIDTH:0]   a_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] d_q;
  logic [CW-1:0]    cnt_q;

  logic [2*WIDTH:0] aq_sh;
  logic [WIDTH:0]   a_sh;
  logic [WIDTH:0]   a_next;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH:0]   sub_diff;
  logic             sub_cout;
  logic             last_step;

  cla_subtractor #(.N(WIDTH + 1)) u_sub (
    .a    (a_sh),
    .b    ({1'b0, d_q}),
    .diff (sub_diff),
    .cout (sub_cout)
  );

  // One restoring step: shift {A,Q}, keep the trial difference only if it did not borrow.
  always_comb begin
    aq_sh     = {a_q, q_q} << 1;
    a_sh      = aq_sh[2*WIDTH:WIDTH];
    a_next    = sub_cout ? sub_diff : a_sh;
    q_next    = {aq_sh[WIDTH-1:1], sub_cout};
    last_step = (cnt_q == CW'(WIDTH - 1));
  end

  // Next-state logic; a start in IDLE or DONE is accepted, a zero divisor skips CALC.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) state_d = (divisor == '0) ? DONE : CALC;
        else       state_d = IDLE;
      end
      CALC:    if (last_step) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      a_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == CALC);
      done    <= (state_d == DONE);
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            if (divisor != '0) begin
              a_q   <= '0;
              q_q   <= dividend;
              d_q   <= divisor;
              cnt_q <= '0;
            end else begin
              quotient    <= DBZ_QUOTIENT[WIDTH-1:0];
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        CALC: begin
          a_q   <= a_next;
          q_q   <= q_next;
          cnt_q <= cnt_q + CW'(1);
          if (last_step) begin
            quotient    <= q_next;
            remainder   <= a_next[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and exhaustive bench for seq_restoring_divider (WIDTH=4) with a result scoreboard.
module tb_seq_restoring_divider;

  localparam int unsigned WIDTH = 4;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dbz;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  exp_t sb[$];
  exp_t mon_e;
  int   checks     = 0;
  int   errors     = 0;
  int   accepted   = 0;
  int   done_count = 0;
  int   lat;

  seq_restoring_divider #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one start request and record its expected result.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    e.a = a;
    e.b = b;
    if (b == '0) begin
      e.q   = '1;
      e.r   = a;
      e.dbz = 1'b1;
    end else begin
      e.q   = a / b;
      e.r   = a % b;
      e.dbz = 1'b0;
    end
    sb.push_back(e);
    accepted++;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Wait for done, counting cycles; an expired budget is a failed check.
  task automatic wait_done(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < budget);
    check("done_timeout", 32'(done), 32'd1);
  endtask

  // Scoreboard: every done pops one expected result.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      done_count++;
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check($sformatf("quot %0d/%0d", mon_e.a, mon_e.b), 32'(quotient), 32'(mon_e.q));
        check($sformatf("rem %0d/%0d", mon_e.a, mon_e.b), 32'(remainder), 32'(mon_e.r));
        check($sformatf("dbz %0d/%0d", mon_e.a, mon_e.b), 32'(div_by_zero), 32'(mon_e.dbz));
        if (!mon_e.dbz) begin
          check($sformatf("identity %0d/%0d", mon_e.a, mon_e.b),
                32'(int'(quotient) * int'(mon_e.b) + int'(remainder)), 32'(mon_e.a));
          check($sformatf("rem_lt_div %0d/%0d", mon_e.a, mon_e.b),
                32'(remainder < mon_e.b), 32'd1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quot", 32'(quotient), 32'd0);
    check("rst_rem", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 13/3: busy for 4 cycles, outputs held, done in the 5th
    issue(4'd13, 4'd3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("t1_busy%0d", i), 32'(busy), 32'd1);
      check($sformatf("t1_done%0d", i), 32'(done), 32'd0);
      check($sformatf("t1_hold%0d", i), 32'(quotient), 32'd0);
    end
    @(negedge clk);
    check("t1_done", 32'(done), 32'd1);
    check("t1_busy_off", 32'(busy), 32'd0);

    // Back-to-back from the DONE cycle
    issue(4'd15, 4'd1);
    wait_done(10, lat);
    check("t2a_lat", 32'(lat), 32'd5);
    issue(4'd0, 4'd5);
    wait_done(10, lat);
    check("t2b_lat", 32'(lat), 32'd5);
    issue(4'd3, 4'd7);
    wait_done(10, lat);
    check("t2c_lat", 32'(lat), 32'd5);

    // Zero divisor, then a normal divide clears the flag
    issue(4'd7, 4'd0);
    wait_done(10, lat);
    check("t3_lat", 32'(lat), 32'd1);
    check("t3_busy", 32'(busy), 32'd0);
    issue(4'd9, 4'd2);
    wait_done(10, lat);
    check("t3b_lat", 32'(lat), 32'd5);

    // Start during CALC is ignored
    issue(4'd12, 4'd5);
    start    = 1'b1;
    dividend = 4'd1;
    divisor  = 4'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(10, lat);
    check("t4_lat", 32'(lat), 32'd4);
    repeat (3) @(negedge clk);
    check("t4_done_count", 32'(done_count), 32'(accepted));

    // Reset after two steps of 14/4
    @(posedge clk);
    #1;
    issue(4'd14, 4'd4);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    void'(sb.pop_back());
    accepted--;
    #1;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_quot", 32'(quotient), 32'd0);
    check("t5_rem", 32'(remainder), 32'd0);
    check("t5_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_idle_busy", 32'(busy), 32'd0);
    check("t5_idle_done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    issue(4'd14, 4'd4);
    wait_done(10, lat);
    check("t5_lat", 32'(lat), 32'd5);

    // Exhaustive sweep, back to back
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        issue(4'(a), 4'(b));
        wait_done(10, lat);
        check($sformatf("sweep_lat %0d/%0d", a, b), 32'(lat), (b == 0) ? 32'd1 : 32'd5);
      end
    end

    repeat (3) @(negedge clk);
    check("final_done_count", 32'(done_count), 32'(accepted));
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
- Iterative unsigned restoring divider; the inverse operation of the team's carry-lookahead adder datapath.
- Computes quotient and remainder of a WIDTH-bit dividend by a WIDTH-bit divisor, one quotient bit per clock.
- Each step's trial subtraction runs on a carry-lookahead subtractor: a + ~b with carry-in 1.
- Sits beside the adder blocks in the arithmetic library; uses a start/busy/done handshake toward a controller.

Parameters:
- WIDTH, 4, operand/quotient/remainder width in bits (legal 2..32).
- CW, $clog2(WIDTH+1), width of the internal iteration counter (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE or DONE.
- dividend  in  WIDTH  unsigned dividend, sampled with an accepted start.
- divisor  in  WIDTH  unsigned divisor, sampled with an accepted start.
- busy  out  1  high while in CALC.
- done  out  1  one-cycle completion pulse.
- quotient  out  WIDTH  registered result.
- remainder  out  WIDTH  registered result.
- div_by_zero  out  1  registered flag, valid with done and held afterwards.

Behaviour:
- Reset (async assert, sync release): state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, all internal registers=0.
- States: IDLE, CALC, DONE.
- IDLE: start=1 at edge k, divisor!=0 -> load A=0 (WIDTH+1 bits), Q=dividend, D=divisor, cnt=0; go to CALC.
- IDLE: start=1 at edge k, divisor==0 -> go directly to DONE with quotient={WIDTH{1}}, remainder=dividend, div_by_zero=1.
- CALC, each edge: shift {A,Q} left by 1; T = A_shifted - {0,D}, computed by the CLA subtractor.
  - If T is non-negative (carry-out=1): A=T, Q[0]=1.
  - Otherwise: A keeps the shifted value, Q[0]=0.
  - cnt increments each step.
- CALC exit: after WIDTH steps (edge k+WIDTH), register quotient=Q, remainder=A[WIDTH-1:0], div_by_zero=0; go to DONE.
- Latency: done=1 during the cycle after edge k+WIDTH. For the zero-divisor case, done=1 during the cycle after edge k.
- busy: 1 exactly in CALC, i.e. WIDTH cycles.
- DONE: done=1 for exactly one cycle.
  - start=1 -> accepted as in IDLE (back-to-back operation).
  - else -> IDLE.
- start while in CALC: ignored, with no effect on the operation in progress.
- Outputs hold their last value until the next completion. They do not change at load or during CALC.
- Arithmetic: all unsigned. The remainder always satisfies remainder < divisor and dividend = quotient*divisor + remainder. A is WIDTH+1 bits so the trial subtraction cannot overflow.
- Reset mid-CALC: immediate return to the reset values; the partial result is discarded.
- dividend < divisor: quotient=0, remainder=dividend, full WIDTH-cycle latency (no early exit).

Decomposition:
- Shared package arith_pkg:
  - state enum {IDLE, CALC, DONE}
  - localparam encodings for the states
  - the divide-by-zero quotient constant (all ones)
- One sub-module, cla_subtractor:
  - parameterized width N (instantiated as WIDTH+1)
  - generate/propagate carry-lookahead
  - b inverted, carry-in tied 1
  - outputs diff[N-1:0] and cout (cout=1 means no borrow)

Test Plan:
- WIDTH=4; 13/3 with start at edge 0 -> busy high 4 cycles; done in cycle 5; quotient=4, remainder=1, div_by_zero=0.
- 15/1 then 0/5 then 3/7, each start issued in the DONE cycle of the previous operation -> results (15,0), (0,0), (0,3), each with no idle gap.
- 7/0 -> done in the cycle after the start edge; busy never high; quotient=15, remainder=7, div_by_zero=1. A following 9/2 -> (4,1) with div_by_zero cleared.
- 12/5 started, then start pulsed with 1/1 during CALC -> result (2,2); the second request is ignored.
- 14/4 started, rst_n dropped at step 2 -> outputs immediately 0 and state IDLE. After release, 14/4 -> (3,2).
- Exhaustive sweep of all 256 dividend/divisor pairs -> the identity and remainder<divisor checks pass; exactly one done per accepted start.
